// File: rtl/riscv_mem_pkg.sv
// Shared memory-access encodings: dm_sel codes used by the decoder, this controller
// and the load-extract stage, plus the access controller's state encoding.
package riscv_mem_pkg;

  localparam logic [2:0] DM_LBU = 3'b000;
  localparam logic [2:0] DM_LHU = 3'b001;
  localparam logic [2:0] DM_LB  = 3'b010;
  localparam logic [2:0] DM_LH  = 3'b100;
  localparam logic [2:0] DM_LW  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/dmem_access_ctrl_store_align.sv
// Byte-lane steering for stores and alignment check for every access size.
module store_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  dm_sel,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  output logic [3:0]  byte_we,
  output logic [31:0] lane_wdata,
  output logic        misalign
);

  always_comb begin
    byte_we    = 4'b0000;
    lane_wdata = 32'h0;
    misalign   = 1'b0;
    case (dm_sel)
      DM_LBU, DM_LB: begin
        byte_we    = 4'b0001 << addr_lo;
        lane_wdata = {4{wdata[7:0]}};
      end
      DM_LHU, DM_LH: begin
        byte_we    = 4'b0011 << {addr_lo[1], 1'b0};
        lane_wdata = {2{wdata[15:0]}};
        misalign   = addr_lo[0];
      end
      DM_LW: begin
        byte_we    = 4'b1111;
        lane_wdata = wdata;
        misalign   = |addr_lo;
      end
      // 011, 110, 111 are unassigned encodings and are rejected like a misalign
      default: misalign = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Load/store access controller in front of a byte-enabled synchronous data SRAM.
// Stores complete in the accept cycle; loads wait RD_LAT cycles and return the raw word.
module dmem_access_ctrl
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_dm_sel,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic [1:0]        rsp_addr_lo,
  output logic [2:0]        rsp_dm_sel,
  output logic              misalign_err,
  output logic              stall,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

  state_t      state;
  logic [1:0]  lat_cnt;
  logic [1:0]  pend_addr_lo;
  logic [2:0]  pend_dm_sel;
  logic [3:0]  byte_we;
  logic [31:0] lane_wdata;
  logic        misalign;
  logic        accept;
  logic        access;
  logic        addr_hi_unused;

  store_align u_store_align (
    .dm_sel     (req_dm_sel),
    .addr_lo    (req_addr[1:0]),
    .wdata      (req_wdata),
    .byte_we    (byte_we),
    .lane_wdata (lane_wdata),
    .misalign   (misalign)
  );

  // Upper byte-address bits alias onto the SRAM; they are deliberately dropped.
  assign addr_hi_unused = ^req_addr[31:ADDR_W+2];

  assign req_ready = rst_n & (state != ST_WAIT);
  assign stall     = req_valid & ~req_ready;
  assign accept    = req_valid & req_ready;
  assign access    = accept & ~misalign;

  assign mem_en    = access;
  assign mem_we    = (access & req_we) ? byte_we : 4'b0000;
  assign mem_addr  = access ? req_addr[ADDR_W+1:2] : '0;
  assign mem_wdata = (access & req_we) ? lane_wdata : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      lat_cnt      <= 2'd0;
      pend_addr_lo <= 2'd0;
      pend_dm_sel  <= 3'd0;
      rsp_valid    <= 1'b0;
      rsp_data     <= 32'h0;
      rsp_addr_lo  <= 2'd0;
      rsp_dm_sel   <= 3'd0;
      misalign_err <= 1'b0;
    end else begin
      rsp_valid    <= 1'b0;
      misalign_err <= accept & misalign;
      case (state)
        ST_WAIT: begin
          if (lat_cnt == 2'd0) begin
            rsp_data    <= mem_rdata;
            rsp_addr_lo <= pend_addr_lo;
            rsp_dm_sel  <= pend_dm_sel;
            rsp_valid   <= 1'b1;
            state       <= ST_RESP;
          end else begin
            lat_cnt <= lat_cnt - 2'd1;
          end
        end
        default: begin
          // IDLE and RESP both accept; only a valid load leaves for WAIT.
          if (access && !req_we) begin
            state        <= ST_WAIT;
            lat_cnt      <= LAT_INIT;
            pend_addr_lo <= req_addr[1:0];
            pend_dm_sel  <= req_dm_sel;
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule
